// File: rtl/usb_token_receiver_pkg.sv
// Shared USB token definitions: PID constants, token/error codes and the CRC5 function.
// Used by both the token receiver and the token generator.
package usb_token_receiver_pkg;

  localparam int unsigned DATA_W = 11;
  localparam int unsigned CRC_W  = 5;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned ENDP_W = 4;

  localparam logic [CRC_W-1:0] CRC5_INIT = 5'b11111;
  localparam logic [CRC_W-1:0] CRC5_POLY = 5'b00101;

  localparam logic [7:0] PID_OUT   = 8'h1E;
  localparam logic [7:0] PID_IN    = 8'h96;
  localparam logic [7:0] PID_SOF   = 8'h5A;
  localparam logic [7:0] PID_SETUP = 8'hD2;

  typedef enum logic [1:0] {
    TOK_OUT   = 2'b00,
    TOK_IN    = 2'b01,
    TOK_SOF   = 2'b10,
    TOK_SETUP = 2'b11
  } tok_type_e;

  typedef enum logic [1:0] {
    ERR_PID = 2'b00,
    ERR_CRC = 2'b01,
    ERR_LEN = 2'b10,
    ERR_PHY = 2'b11
  } tok_err_e;

  // Fields held from the last good token
  typedef struct packed {
    tok_type_e          tok_type;
    logic [ADDR_W-1:0]  addr;
    logic [ENDP_W-1:0]  endp;
    logic [DATA_W-1:0]  frame;
  } tok_info_t;

  // CRC5 over data[0..10], LSB first, shift-left form, inverted result
  function automatic logic [CRC_W-1:0] crc5(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = CRC5_INIT;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb = data[i] ^ c[CRC_W-1];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC5_POLY;
    end
    return ~c;
  endfunction

endpackage

// File: rtl/usb_token_receiver_if.sv
// UTMI receive bus plus decoded-token outputs of the token receiver.
interface usb_token_receiver_if;
  import usb_token_receiver_pkg::*;

  logic [7:0]        utmi_rx_data;
  logic              utmi_rx_valid;
  logic              utmi_rx_active;
  logic              utmi_rx_error;

  logic              tok_valid;
  tok_type_e         tok_type;
  logic [ADDR_W-1:0] tok_addr;
  logic [ENDP_W-1:0] tok_endp;
  logic [DATA_W-1:0] tok_frame;
  logic              tok_err;
  tok_err_e          tok_err_code;
  logic              rx_busy;

  modport master (
    output utmi_rx_data, utmi_rx_valid, utmi_rx_active, utmi_rx_error,
    input  tok_valid, tok_type, tok_addr, tok_endp, tok_frame, tok_err, tok_err_code, rx_busy
  );

  modport slave (
    input  utmi_rx_data, utmi_rx_valid, utmi_rx_active, utmi_rx_error,
    output tok_valid, tok_type, tok_addr, tok_endp, tok_frame, tok_err, tok_err_code, rx_busy
  );

endinterface

// File: rtl/usb_crc5_check.sv
// Combinational CRC5 match of an 11-bit token payload against the received CRC.
module usb_crc5_check
  import usb_token_receiver_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [CRC_W-1:0]  crc_rx_i,
  output logic              match_c
);

  assign match_c = (crc5(data_i) == crc_rx_i);

endmodule

// File: rtl/usb_token_receiver.sv
// USB token packet receiver: decodes OUT/IN/SETUP/SOF tokens from the UTMI
// receive stream and reports either one good token or one rejection per packet.
module usb_token_receiver
  import usb_token_receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  usb_token_receiver_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_BYTE0, ST_BYTE1, ST_WAIT_EOP, ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CRC_W-1:0]  crc_rx_q, crc_rx_d;
  tok_type_e         pid_type_q, pid_type_d;
  logic              err_seen_q, err_seen_d;
  logic              tok_valid_q, tok_valid_d;
  logic              tok_err_q, tok_err_d;
  tok_err_e          err_code_q, err_code_d;
  tok_info_t         info_q, info_d;
  logic              rx_busy_q, rx_busy_d;

  logic              rise_c;
  logic              phy_err_c;
  logic              crc_ok_c;
  logic [7:0]        rx_byte_c;

  usb_crc5_check u_crc5_check (
    .data_i   (data_q),
    .crc_rx_i (crc_rx_q),
    .match_c  (crc_ok_c)
  );

  assign rx_byte_c = bus.utmi_rx_data;
  assign rise_c    = bus.utmi_rx_active && !active_q;
  assign phy_err_c = (state_q != ST_IDLE) && bus.utmi_rx_error;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    active_d    = bus.utmi_rx_active;
    data_d      = data_q;
    crc_rx_d    = crc_rx_q;
    pid_type_d  = pid_type_q;
    err_seen_d  = err_seen_q;
    tok_valid_d = 1'b0;
    tok_err_d   = 1'b0;
    err_code_d  = err_code_q;
    info_d      = info_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rise_c) begin
          state_d    = ST_PID;
          err_seen_d = 1'b0;
        end
      end
      ST_PID: begin
        if (!bus.utmi_rx_active) begin
          state_d = ST_IDLE; tok_err_d = 1'b1; err_code_d = ERR_LEN; err_seen_d = 1'b1;
        end else if (bus.utmi_rx_valid) begin
          if (rx_byte_c[7:4] != ~rx_byte_c[3:0]) begin
            state_d = ST_DRAIN; tok_err_d = 1'b1; err_code_d = ERR_PID; err_seen_d = 1'b1;
          end else begin
            state_d = ST_BYTE0;
            case (rx_byte_c)
              PID_OUT:   pid_type_d = TOK_OUT;
              PID_IN:    pid_type_d = TOK_IN;
              PID_SOF:   pid_type_d = TOK_SOF;
              PID_SETUP: pid_type_d = TOK_SETUP;
              default:   state_d    = ST_DRAIN;  // valid PID, but not a token
            endcase
          end
        end
      end
      ST_BYTE0: begin
        if (!bus.utmi_rx_active) begin
          state_d = ST_IDLE; tok_err_d = 1'b1; err_code_d = ERR_LEN; err_seen_d = 1'b1;
        end else if (bus.utmi_rx_valid) begin
          state_d     = ST_BYTE1;
          data_d[7:0] = rx_byte_c;
        end
      end
      ST_BYTE1: begin
        if (!bus.utmi_rx_active) begin
          state_d = ST_IDLE; tok_err_d = 1'b1; err_code_d = ERR_LEN; err_seen_d = 1'b1;
        end else if (bus.utmi_rx_valid) begin
          state_d      = ST_WAIT_EOP;
          data_d[10:8] = rx_byte_c[2:0];
          crc_rx_d     = rx_byte_c[7:3];
        end
      end
      ST_WAIT_EOP: begin
        if (!bus.utmi_rx_active) begin
          state_d = ST_IDLE;
          if (crc_ok_c) begin
            tok_valid_d     = 1'b1;
            info_d.tok_type = pid_type_q;
            if (pid_type_q == TOK_SOF) begin
              info_d.frame = data_q;
            end else begin
              info_d.addr = data_q[6:0];
              info_d.endp = data_q[10:7];
            end
          end else begin
            tok_err_d = 1'b1; err_code_d = ERR_CRC; err_seen_d = 1'b1;
          end
        end else if (bus.utmi_rx_valid) begin
          state_d = ST_DRAIN; tok_err_d = 1'b1; err_code_d = ERR_LEN; err_seen_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!bus.utmi_rx_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // PHY error overrides everything else, but a packet reports at most one error
    if (phy_err_c) begin
      state_d     = ST_DRAIN;
      tok_valid_d = 1'b0;
      info_d      = info_q;
      tok_err_d   = !err_seen_q;
      err_code_d  = err_seen_q ? err_code_q : ERR_PHY;
      err_seen_d  = 1'b1;
    end
  end

  assign rx_busy_d = (state_d != ST_IDLE);

  // Synchronous reset; active_q resets high so a packet already in flight is not armed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b1;
      data_q      <= '0;
      crc_rx_q    <= '0;
      pid_type_q  <= TOK_OUT;
      err_seen_q  <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_err_q   <= 1'b0;
      err_code_q  <= ERR_PID;
      info_q      <= '0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      data_q      <= data_d;
      crc_rx_q    <= crc_rx_d;
      pid_type_q  <= pid_type_d;
      err_seen_q  <= err_seen_d;
      tok_valid_q <= tok_valid_d;
      tok_err_q   <= tok_err_d;
      err_code_q  <= err_code_d;
      info_q      <= info_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign bus.tok_valid    = tok_valid_q;
  assign bus.tok_err      = tok_err_q;
  assign bus.tok_err_code = err_code_q;
  assign bus.tok_type     = info_q.tok_type;
  assign bus.tok_addr     = info_q.addr;
  assign bus.tok_endp     = info_q.endp;
  assign bus.tok_frame    = info_q.frame;
  assign bus.rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_usb_token_receiver.sv
// Bench for usb_token_receiver: packet-level outcome model with per-cycle output checking.
module tb_usb_token_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_token_receiver_if bus_if();

  usb_token_receiver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int rise_e = 0;
  int end_e  = 0;

  // Expected pulse per clock edge: kind 1 = good token, 2 = rejection
  int exp_kind[int];
  int exp_code[int];
  int exp_ty[int];
  int exp_d[int];

  int m_type = 0, m_addr = 0, m_endp = 0, m_frame = 0;
  int seen_valid = 0, seen_err = 0, seen_code = -1;

  logic [7:0] pk[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Reference CRC5 on plain integers
  function automatic int crc5_ref(input int d);
    int r, top, b;
    r = 31;
    for (int i = 0; i < 11; i++) begin
      top = (r >> 4) & 1;
      b   = (d >> i) & 1;
      r   = (r << 1) & 31;
      if ((top ^ b) != 0) r = r ^ 5;
    end
    return (~r) & 31;
  endfunction

  // Per-cycle compare, 1 time unit after each rising edge
  always @(posedge clk) begin
    int ev;
    edge_n++;
    #1;
    if (!rst_n) begin
      m_type = 0; m_addr = 0; m_endp = 0; m_frame = 0;
      chk("rst_tok_valid", 32'(bus_if.tok_valid), 0);
      chk("rst_tok_err", 32'(bus_if.tok_err), 0);
      chk("rst_err_code", 32'(bus_if.tok_err_code), 0);
      chk("rst_tok_type", 32'(bus_if.tok_type), 0);
      chk("rst_tok_addr", 32'(bus_if.tok_addr), 0);
      chk("rst_tok_endp", 32'(bus_if.tok_endp), 0);
      chk("rst_tok_frame", 32'(bus_if.tok_frame), 0);
      chk("rst_rx_busy", 32'(bus_if.rx_busy), 0);
    end else begin
      ev = exp_kind.exists(edge_n) ? exp_kind[edge_n] : 0;
      if (ev == 1) begin
        m_type = exp_ty[edge_n];
        if (m_type == 2) m_frame = exp_d[edge_n];
        else begin
          m_addr = exp_d[edge_n] % 128;
          m_endp = exp_d[edge_n] / 128;
        end
      end
      chk("tok_valid", 32'(bus_if.tok_valid), (ev == 1) ? 1 : 0);
      chk("tok_err", 32'(bus_if.tok_err), (ev == 2) ? 1 : 0);
      if (ev == 2) chk("tok_err_code", 32'(bus_if.tok_err_code), exp_code[edge_n]);
      chk("tok_type", 32'(bus_if.tok_type), m_type);
      chk("tok_addr", 32'(bus_if.tok_addr), m_addr);
      chk("tok_endp", 32'(bus_if.tok_endp), m_endp);
      chk("tok_frame", 32'(bus_if.tok_frame), m_frame);
      chk("rx_busy", 32'(bus_if.rx_busy), (edge_n >= rise_e && edge_n < end_e) ? 1 : 0);
      if (bus_if.tok_valid === 1'b1) seen_valid++;
      if (bus_if.tok_err === 1'b1) begin
        seen_err++;
        seen_code = int'(bus_if.tok_err_code);
      end
    end
  end

  // Drive one cycle of UTMI inputs; e is the edge that samples them
  task automatic drive(input bit a, input bit v, input logic [7:0] d, input bit er, output int e);
    @(negedge clk);
    bus_if.utmi_rx_active = a;
    bus_if.utmi_rx_valid  = v;
    bus_if.utmi_rx_data   = d;
    bus_if.utmi_rx_error  = er;
    e = edge_n + 1;
  endtask

  // Play pk[0..n-1] as one packet and record the outcome the token rules demand
  task automatic send_pkt(input int n, input int err_before, input int gapmax);
    int e, ty;
    bit alive, err_done;
    logic [10:0] d;
    logic [4:0]  c;
    alive = 1'b1; err_done = 1'b0; ty = 0; d = '0; c = '0;
    drive(1'b1, 1'b0, 8'($urandom), 1'b0, e);
    rise_e = e; end_e = 2147483647;
    for (int i = 0; i <= n; i++) begin
      if (i == err_before) begin
        drive(1'b1, 1'b0, 8'($urandom), 1'b1, e);
        if (!err_done) begin exp_kind[e] = 2; exp_code[e] = 3; end
        err_done = 1'b1; alive = 1'b0;
      end
      repeat ($urandom_range(0, gapmax)) drive(1'b1, 1'b0, 8'($urandom), 1'b0, e);
      if (i < n) begin
        drive(1'b1, 1'b1, pk[i], 1'b0, e);
        if (alive) begin
          if (i == 0) begin
            if (pk[0][7:4] != ~pk[0][3:0]) begin
              exp_kind[e] = 2; exp_code[e] = 0; err_done = 1'b1; alive = 1'b0;
            end else begin
              case (pk[0])
                8'h1E:   ty = 0;
                8'h96:   ty = 1;
                8'h5A:   ty = 2;
                8'hD2:   ty = 3;
                default: alive = 1'b0;
              endcase
            end
          end else if (i == 1) begin
            d[7:0] = pk[1];
          end else if (i == 2) begin
            d[10:8] = pk[2][2:0];
            c       = pk[2][7:3];
          end else begin
            exp_kind[e] = 2; exp_code[e] = 2; err_done = 1'b1; alive = 1'b0;
          end
        end
      end
    end
    drive(1'b0, 1'b0, 8'($urandom), 1'b0, e);
    end_e = e;
    if (alive) begin
      if (n < 3) begin
        exp_kind[e] = 2; exp_code[e] = 2;
      end else if (crc5_ref(int'(d)) == int'(c)) begin
        exp_kind[e] = 1; exp_ty[e] = ty; exp_d[e] = int'(d);
      end else begin
        exp_kind[e] = 2; exp_code[e] = 1;
      end
    end
  endtask

  task automatic set_token(input logic [7:0] pid, input logic [10:0] d);
    pk[0] = pid;
    pk[1] = d[7:0];
    pk[2] = {5'(crc5_ref(int'(d))), d[2+8:8]};
  endtask

  task automatic idle(input int cycles);
    int e;
    repeat (cycles) drive(1'b0, 1'b0, 8'($urandom), 1'b0, e);
  endtask

  task automatic rand_pkt();
    int n, r, eb;
    logic [10:0] d;
    logic [4:0]  c;
    logic [3:0]  nib;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    pk[0] = 8'h1E;
      2, 3:    pk[0] = 8'h96;
      4:       pk[0] = 8'h5A;
      5:       pk[0] = 8'hD2;
      6:       pk[0] = 8'hC3;
      7:       begin nib = 4'($urandom); pk[0] = {nib, ~nib}; end
      default: pk[0] = 8'($urandom);
    endcase
    d = 11'($urandom);
    c = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(crc5_ref(int'(d)));
    pk[1] = d[7:0];
    pk[2] = {c, d[10:8]};
    for (int i = 3; i < 8; i++) pk[i] = 8'($urandom);
    r = $urandom_range(0, 9);
    n = (r <= 5) ? 3 : (r == 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : $urandom_range(4, 5);
    eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n) : -1;
    send_pkt(n, eb, 2);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    int e, v0, e0;
    bus_if.utmi_rx_active = 1'b0;
    bus_if.utmi_rx_valid  = 1'b0;
    bus_if.utmi_rx_data   = 8'h00;
    bus_if.utmi_rx_error  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("crc5_model_pin", 32'(crc5_ref(0)), 32'h08);
    idle(2);

    // IN addr 15h endp 3
    v0 = seen_valid;
    set_token(8'h96, {4'h3, 7'h15});
    send_pkt(3, -1, 1);
    idle(2);
    chk("in_count", 32'(seen_valid - v0), 1);
    chk("in_type", 32'(bus_if.tok_type), 32'h1);
    chk("in_addr", 32'(bus_if.tok_addr), 32'h15);
    chk("in_endp", 32'(bus_if.tok_endp), 32'h3);

    // SOF frame 7FFh, address held
    set_token(8'h5A, 11'h7FF);
    send_pkt(3, -1, 1);
    idle(1);
    chk("sof_type", 32'(bus_if.tok_type), 32'h2);
    chk("sof_frame", 32'(bus_if.tok_frame), 32'h7FF);
    chk("sof_addr", 32'(bus_if.tok_addr), 32'h15);

    // SETUP with BYTE0 bit0 flipped
    v0 = seen_valid; e0 = seen_err;
    set_token(8'hD2, {4'h5, 7'h2A});
    pk[1] = pk[1] ^ 8'h01;
    send_pkt(3, -1, 1);
    idle(1);
    chk("setup_crc_err_code", 32'(seen_code), 1);
    chk("setup_crc_no_valid", 32'(seen_valid - v0), 0);
    chk("setup_crc_err_count", 32'(seen_err - e0), 1);

    // Bad PID check
    set_token(8'h1F, 11'h123);
    send_pkt(3, -1, 0);
    idle(1);
    chk("pid_err_code", 32'(seen_code), 0);

    // DATA0 followed by 4 bytes: silently drained
    v0 = seen_valid; e0 = seen_err;
    pk[0] = 8'hC3; pk[1] = 8'h11; pk[2] = 8'h22; pk[3] = 8'h33; pk[4] = 8'h44;
    send_pkt(5, -1, 1);
    idle(1);
    chk("data0_no_valid", 32'(seen_valid - v0), 0);
    chk("data0_no_err", 32'(seen_err - e0), 0);

    // OUT plus a 4th byte, then OUT cut short after 2 bytes
    set_token(8'h1E, 11'h456);
    pk[3] = 8'hAA;
    send_pkt(4, -1, 1);
    idle(1);
    chk("long_err_code", 32'(seen_code), 2);
    set_token(8'h1E, 11'h456);
    send_pkt(2, -1, 1);
    idle(1);
    chk("short_err_code", 32'(seen_code), 2);

    // PHY error while in BYTE0
    e0 = seen_err;
    set_token(8'h96, 11'h0F0);
    send_pkt(3, 1, 1);
    idle(1);
    chk("phy_err_code", 32'(seen_code), 3);
    chk("phy_err_count", 32'(seen_err - e0), 1);

    // Reset while in BYTE1, active still high after release
    v0 = seen_valid; e0 = seen_err;
    drive(1'b1, 1'b0, 8'h00, 1'b0, e);
    rise_e = e; end_e = 2147483647;
    drive(1'b1, 1'b1, 8'h96, 1'b0, e);
    drive(1'b1, 1'b1, 8'h15, 1'b0, e);
    drive(1'b1, 1'b0, 8'h00, 1'b0, e);
    rst_n = 1'b0;
    end_e = e;
    drive(1'b1, 1'b0, 8'h00, 1'b0, e);
    drive(1'b1, 1'b1, 8'h1E, 1'b0, e);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h15, 1'b0, e);
    drive(1'b1, 1'b0, 8'h00, 1'b0, e);
    idle(2);
    chk("rst_abort_no_pulse", 32'(seen_valid - v0 + seen_err - e0), 0);
    set_token(8'h96, {4'h7, 7'h33});
    send_pkt(3, -1, 0);
    idle(1);
    chk("post_rst_count", 32'(seen_valid - v0), 1);
    chk("post_rst_addr", 32'(bus_if.tok_addr), 32'h33);

    // Randomized packets, some back-to-back
    repeat (250) rand_pkt();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_token_receiver.md
USB_TOKEN_RECEIVER -- requirements
Module: usb_token_receiver

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port utmi_rx_data, input, 8, the received byte.
REQ-004 SHALL have port utmi_rx_valid, input, 1, utmi_rx_data valid this cycle.
REQ-005 SHALL have port utmi_rx_active, input, 1, a packet is in progress; it frames the packet.
REQ-006 SHALL have port utmi_rx_error, input, 1, PHY receive error.
REQ-007 SHALL have port tok_valid, output, 1, one-cycle pulse that a good token was decoded.
REQ-008 SHALL have port tok_type, output, 2, 00=OUT, 01=IN, 10=SOF, 11=SETUP.
REQ-009 SHALL have port tok_addr, output, 7, device address.
REQ-010 SHALL have port tok_endp, output, 4, endpoint number.
REQ-011 SHALL have port tok_frame, output, 11, SOF frame number.
REQ-012 SHALL have port tok_err, output, 1, one-cycle pulse that a token was rejected.
REQ-013 SHALL have port tok_err_code, output, 2, 00=PID, 01=CRC, 10=length, 11=PHY; valid with tok_err.
REQ-014 SHALL have port rx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL use states IDLE, PID, BYTE0, BYTE1, WAIT_EOP, DRAIN.
REQ-016 SHALL leave IDLE for PID on the rising edge of utmi_rx_active. Bytes are taken only when utmi_rx_valid=1.
REQ-017 SHALL check the PID byte: pass when byte[7:4] == ~byte[3:0], else fail with tok_err code PID, then go to DRAIN.
REQ-018 SHALL accept these token PID byte values: OUT 8'h1E, IN 8'h96, SOF 8'h5A, SETUP 8'hD2. These match the token generator's encoding.
REQ-019 SHALL treat a PID byte that passes the check but is not a token PID as not ours: DRAIN with no tok_valid and no tok_err.
REQ-020 SHALL capture BYTE0 as data[7:0], and BYTE1 as data[10:8]=byte[2:0] with crc_rx=byte[7:3].
REQ-021 SHALL compute the CRC5 over data[0..10], LSB first: init 5'b11111, polynomial 5'b00101, shift-left form, final inversion. Mismatch with crc_rx gives tok_err code CRC.
REQ-022 SHALL use WAIT_EOP after BYTE1: if utmi_rx_active falls with no further valid byte, evaluate the CRC. A further valid byte gives tok_err code length, then DRAIN.
REQ-023 SHALL give tok_err code length, then IDLE, when utmi_rx_active falls in PID, BYTE0 or BYTE1.
REQ-024 SHALL give tok_err code PHY and go to DRAIN when utmi_rx_error=1 in any non-IDLE state. PHY takes priority over all other errors in the same cycle.
REQ-025 SHALL assert tok_valid or tok_err exactly one cycle after the cycle in which utmi_rx_active is sampled low in WAIT_EOP, then return to IDLE.
REQ-026 SHALL, on good IN/OUT/SETUP tokens, set tok_addr=data[6:0] and tok_endp=data[10:7], with tok_frame unchanged. On good SOF tokens it SHALL set tok_frame=data[10:0], with tok_addr and tok_endp unchanged.
REQ-027 SHALL hold tok_type/tok_addr/tok_endp/tok_frame from the last good token until the next one.
REQ-028 SHALL let DRAIN ignore all bytes and return to IDLE in the cycle after utmi_rx_active is low. At most one tok_err SHALL be reported per packet.
REQ-029 SHALL recognise a new utmi_rx_active rise as soon as the block is back in IDLE, giving back-to-back packets with a one-cycle gap.
REQ-030 SHALL never assert tok_valid and tok_err in the same cycle.

Reset
REQ-031 SHALL, with rst_n=0 at a clk edge, set state=IDLE, tok_valid=0, tok_err=0, tok_err_code=00, tok_type=00, tok_addr=0, tok_endp=0, tok_frame=0, rx_busy=0.
REQ-032 SHALL let reset mid-packet abandon the packet with no pulse. After release, if utmi_rx_active is already high, the block SHALL wait for it to go low before arming.

Structure
REQ-033 SHALL take the token-type codes, PID byte constants, error codes and the CRC5 function from the shared usb package; the token generator uses the same package.
REQ-034 SHALL contain one sub-module, usb_crc5_check: 11-bit data plus 5-bit received CRC in, combinational match flag out.

Verification
REQ-035 SHALL verify: IN byte 8'h96, addr 7'h15, endp 4'h3, correct CRC, then active low -> one tok_valid, tok_type=01, tok_addr=15h, tok_endp=3.
REQ-036 SHALL verify: SOF byte 8'h5A, frame 11'h7FF, correct CRC -> tok_valid, tok_type=10, tok_frame=7FFh, tok_addr unchanged.
REQ-037 SHALL verify: a SETUP token with BYTE0 bit0 flipped -> tok_err code 01, no tok_valid.
REQ-038 SHALL verify: PID byte 8'h1F -> tok_err code 00; a DATA0 byte 8'hC3 followed by 4 bytes -> no pulse, rx_busy until active low.
REQ-039 SHALL verify: an OUT token plus a 4th byte -> tok_err code 10; an OUT token with active dropping after 2 bytes -> tok_err code 10.
REQ-040 SHALL verify: utmi_rx_error during BYTE0 -> single tok_err code 11. Also rst_n low during BYTE1 -> no pulse, and the next packet decodes normally.
